// File: rtl/fma_issue_arbiter_pkg.sv
// Shared definitions for the FMA issue arbiter slice.
// Holds the default datapath geometry, the op-bit encoding carried on
// req_op/fma_op and a ceiling-log2 helper used to size ID, pointer and
// credit fields.
package fma_issue_arbiter_pkg;

  localparam int unsigned EXP_WIDTH       = 8;
  localparam int unsigned SIG_WIDTH       = 23;
  localparam int unsigned DEF_DATA_WIDTH  = EXP_WIDTH + SIG_WIDTH + 1;
  localparam int unsigned DEF_FMA_LATENCY = 4;

  // Bit positions inside a 2-bit op field.
  localparam int unsigned NEG_PROD = 1;
  localparam int unsigned NEG_ADD  = 0;

  // Ceiling log2, never less than 1 so every derived field has a real bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 1;
    for (int unsigned k = 1; k < 32; k++) begin
      if ((32'd1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fma_issue_arbiter_rr_arbiter.sv
// Round-robin arbiter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   eligible   : per-requester eligibility
//   grant      : one-hot grant (or zero), combinational
//   grantId    : index of the granted requester (0 when no grant)
// The search starts one past the last granted requester; the pointer only
// moves when something is granted.
module fma_issue_arbiter_rr_arbiter
  import fma_issue_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        eligible,
  output logic [NUM_REQ-1:0]        grant,
  output logic [clog2(NUM_REQ)-1:0] grantId
);

  localparam int unsigned IDW = clog2(NUM_REQ);

  logic [IDW-1:0] rrPtr;
  logic [IDW-1:0] cand;
  logic           found;

  always_comb begin
    grant   = '0;
    grantId = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((32'(rrPtr) + k) % NUM_REQ);
      if (!found && eligible[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grantId     = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rrPtr <= IDW'(NUM_REQ - 1);
    end else if (found) begin
      rrPtr <= grantId;
    end
  end

endmodule

// File: rtl/fma_issue_arbiter.sv
// Shares one fixed-latency FMA datapath among NUM_REQ requesters.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   req_valid/req_ready     : per-requester request handshake (ready one-hot)
//   req_a/b/c, req_op       : packed operands / op bits, requester i at slice i
//   fma_issue, fma_a/b/c/op : operands into the datapath (zero when idle)
//   fma_res_valid, fma_res  : datapath result, FMA_LATENCY cycles after issue
//   rsp_valid/rsp_ready     : per-requester response FIFO handshake
//   rsp_data                : packed FIFO heads
//   tag_err                 : sticky result/tag misalignment flag
// Each requester holds RSP_DEPTH credits; a credit is spent at issue and
// returned when its response is popped (or when its tag retires without a
// result), so a response FIFO can never be pushed while full.
module fma_issue_arbiter
  import fma_issue_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned FMA_LATENCY = DEF_FMA_LATENCY,
  parameter int unsigned RSP_DEPTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_c,
  input  logic [NUM_REQ*2-1:0]          req_op,
  output logic                          fma_issue,
  output logic [DATA_WIDTH-1:0]         fma_a,
  output logic [DATA_WIDTH-1:0]         fma_b,
  output logic [DATA_WIDTH-1:0]         fma_c,
  output logic [1:0]                    fma_op,
  input  logic                          fma_res_valid,
  input  logic [DATA_WIDTH-1:0]         fma_res,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data,
  output logic                          tag_err
);

  localparam int unsigned IDW = clog2(NUM_REQ);
  localparam int unsigned CW  = clog2(RSP_DEPTH + 1);
  localparam int unsigned PW  = clog2(RSP_DEPTH);

  logic [NUM_REQ-1:0]                eligible;
  logic [NUM_REQ-1:0]                grant;
  logic [IDW-1:0]                    grantId;
  logic [FMA_LATENCY-1:0]            tagValid;
  logic [FMA_LATENCY-1:0][IDW-1:0]   tagId;
  logic                              tagValidLast;
  logic [IDW-1:0]                    tagIdLast;

  fma_issue_arbiter_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) uArb (
    .clk     (clk),
    .rst_n   (rst_n),
    .eligible(eligible),
    .grant   (grant),
    .grantId (grantId)
  );

  assign req_ready = grant;
  assign fma_issue = |grant;

  always_comb begin
    fma_a  = '0;
    fma_b  = '0;
    fma_c  = '0;
    fma_op = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        fma_a            = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        fma_b            = req_b[i*DATA_WIDTH +: DATA_WIDTH];
        fma_c            = req_c[i*DATA_WIDTH +: DATA_WIDTH];
        fma_op[NEG_PROD] = req_op[i*2 + NEG_PROD];
        fma_op[NEG_ADD]  = req_op[i*2 + NEG_ADD];
      end
    end
  end

  // Requester ID travels alongside the datapath; no stall, shifts every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tagValid <= '0;
      tagId    <= '0;
    end else begin
      tagValid[0] <= fma_issue;
      tagId[0]    <= grantId;
      for (int unsigned s = 1; s < FMA_LATENCY; s++) begin
        tagValid[s] <= tagValid[s-1];
        tagId[s]    <= tagId[s-1];
      end
    end
  end

  assign tagValidLast = tagValid[FMA_LATENCY-1];
  assign tagIdLast    = tagId[FMA_LATENCY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_err <= 1'b0;
    end else if (fma_res_valid != tagValidLast) begin
      tag_err <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : gReq
    logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
    logic [PW-1:0]         wrPtr;
    logic [PW-1:0]         rdPtr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         credit;
    logic                  tagMine;
    logic                  push;
    logic                  pop;
    logic                  retire;
    logic                  take;

    assign tagMine = tagValidLast & (tagIdLast == IDW'(i));
    assign push    = fma_res_valid & tagMine;
    // A tag that retires with no result still owes its requester the credit.
    assign retire  = ~fma_res_valid & tagMine;
    assign pop     = rsp_valid[i] & rsp_ready[i];
    assign take    = grant[i];

    // Gated by rst_n so req_ready reads zero while reset is held.
    assign eligible[i]  = req_valid[i] & (credit != '0) & rst_n;
    assign rsp_valid[i] = (count != '0);
    assign rsp_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[rdPtr];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wrPtr  <= '0;
        rdPtr  <= '0;
        count  <= '0;
        credit <= CW'(RSP_DEPTH);
        for (int unsigned e = 0; e < RSP_DEPTH; e++) mem[e] <= '0;
      end else begin
        if (push) begin
          mem[wrPtr] <= fma_res;
          wrPtr      <= (wrPtr == PW'(RSP_DEPTH - 1)) ? '0 : wrPtr + 1'b1;
        end
        if (pop) begin
          rdPtr <= (rdPtr == PW'(RSP_DEPTH - 1)) ? '0 : rdPtr + 1'b1;
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        credit <= credit + CW'(pop) + CW'(retire) - CW'(take);
      end
    end

    assert property (@(posedge clk) disable iff (!rst_n) credit <= CW'(RSP_DEPTH));
    assert property (@(posedge clk) disable iff (!rst_n) !(take && credit == '0));
    assert property (@(posedge clk) disable iff (!rst_n)
      (32'(credit) + 32'(pop) + 32'(retire)) <= (RSP_DEPTH + 32'(take)));
    assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !pop && count == CW'(RSP_DEPTH)));
  end

endmodule

// File: tb/tb_fma_issue_arbiter.sv
// Bench for fma_issue_arbiter: directed stimulus, a stand-in FMA datapath
// and a per-requester scoreboard popped by a separate monitor.
module tb_fma_issue_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int LAT = 4;

  logic           clk;
  logic           rst_n;
  logic [NR-1:0]  reqValid;
  logic [NR-1:0]  req_ready;
  logic [NR*DW-1:0] reqA, reqB, reqC;
  logic [NR*2-1:0]  reqOp;
  logic           fma_issue;
  logic [DW-1:0]  fma_a, fma_b, fma_c;
  logic [1:0]     fma_op;
  logic           fmaResValid;
  logic [DW-1:0]  fmaRes;
  logic [NR-1:0]  rsp_valid;
  logic [NR-1:0]  rspReady;
  logic [NR*DW-1:0] rsp_data;
  logic           tag_err;

  logic [DW-1:0]  aIn [NR];
  logic [DW-1:0]  bIn [NR];
  logic [DW-1:0]  cIn [NR];
  logic [1:0]     opIn [NR];

  logic [LAT-1:0] dpValid = '0;
  logic [DW-1:0]  dpData [LAT];
  logic           inject;
  logic [DW-1:0]  injData;

  logic [DW-1:0]  expQ [NR][$];
  int             nCompared = 0;
  int             nMismatch = 0;

  fma_issue_arbiter #(
    .NUM_REQ(NR),
    .DATA_WIDTH(DW),
    .FMA_LATENCY(LAT),
    .RSP_DEPTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(reqValid), .req_ready(req_ready),
    .req_a(reqA), .req_b(reqB), .req_c(reqC), .req_op(reqOp),
    .fma_issue(fma_issue), .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_op(fma_op),
    .fma_res_valid(fmaResValid), .fma_res(fmaRes),
    .rsp_valid(rsp_valid), .rsp_ready(rspReady), .rsp_data(rsp_data),
    .tag_err(tag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    reqA  = '0;
    reqB  = '0;
    reqC  = '0;
    reqOp = '0;
    for (int i = 0; i < NR; i++) begin
      reqA[i*DW +: DW] = aIn[i];
      reqB[i*DW +: DW] = bIn[i];
      reqC[i*DW +: DW] = cIn[i];
      reqOp[i*2 +: 2]  = opIn[i];
    end
  end

  // Stand-in for the real FMA: any fixed function works, only routing matters.
  function automatic logic [DW-1:0] fmaModel(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [DW-1:0] c, input logic [1:0] op);
    return (a + b) ^ c ^ {op, 30'd0};
  endfunction

  // Datapath keeps running through reset, like the real one would.
  always @(posedge clk) begin
    dpValid   <= {dpValid[LAT-2:0], fma_issue};
    dpData[0] <= fmaModel(fma_a, fma_b, fma_c, fma_op);
    for (int s = 1; s < LAT; s++) dpData[s] <= dpData[s-1];
  end

  assign fmaResValid = dpValid[LAT-1] | inject;
  assign fmaRes      = inject ? injData : dpData[LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: record accepted requests, compare every popped response.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) expQ[i].delete();
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (rsp_valid[i] && rspReady[i]) begin
          if (expQ[i].size() == 0) begin
            nCompared++;
            nMismatch++;
            $display("FAIL rsp_unexpected[%0d]: got 0x%0h, expected no response", i, rsp_data[i*DW +: DW]);
          end else begin
            check($sformatf("rsp_data[%0d]", i), 64'(rsp_data[i*DW +: DW]), 64'(expQ[i].pop_front()));
          end
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (req_ready[i]) expQ[i].push_back(fmaModel(aIn[i], bIn[i], cIn[i], opIn[i]));
      end
    end
  end

  int grants;
  int g;
  int total;

  initial begin
    rst_n    = 1'b0;
    reqValid = '0;
    rspReady = '0;
    inject   = 1'b0;
    injData  = '0;
    for (int i = 0; i < NR; i++) begin
      aIn[i] = '0; bIn[i] = '0; cIn[i] = '0; opIn[i] = '0;
    end
    repeat (2) tick();
    check("reset_req_ready", req_ready, 0);
    check("reset_fma_issue", fma_issue, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_tag_err", tag_err, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single request from requester 2.
    aIn[2] = 32'h3F800000; bIn[2] = 32'h40000000; cIn[2] = 32'h40400000; opIn[2] = 2'b00;
    reqValid = 4'b0100;
    rspReady = 4'b1111;
    @(negedge clk);
    check("t1_req_ready", req_ready, 4'b0100);
    check("t1_fma_issue", fma_issue, 1);
    check("t1_fma_a", fma_a, 32'h3F800000);
    check("t1_fma_b", fma_b, 32'h40000000);
    check("t1_fma_c", fma_c, 32'h40400000);
    tick();
    reqValid = '0;
    repeat (3) tick();
    @(negedge clk);
    check("t1_rsp_valid_t4", rsp_valid, 0);
    tick();
    @(negedge clk);
    check("t1_rsp_valid_t5", rsp_valid, 4'b0100);
    tick();
    @(negedge clk);
    check("t1_rsp_popped", rsp_valid, 0);

    // Round-robin with everyone requesting; last grant was 2, so start at 3.
    tick();
    reqValid = '1;
    rspReady = '1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NR; i++) begin
        aIn[i]  = 32'h1000_0000 * (i + 1) + k;
        bIn[i]  = 32'h0100_0000 + i;
        cIn[i]  = 32'h0000_1000 * k;
        opIn[i] = 2'(i);
      end
      g = (3 + k) % NR;
      @(negedge clk);
      check($sformatf("t2_grant_%0d", k), req_ready, 64'(4'b0001 << g));
      check($sformatf("t2_fma_a_%0d", k), fma_a, aIn[g]);
      check($sformatf("t2_fma_op_%0d", k), fma_op, opIn[g]);
      tick();
    end
    reqValid = '0;
    repeat (8) tick();

    // Credit stall: requester 1 streams while its responses are not popped.
    reqValid = 4'b0010;
    rspReady = 4'b1101;
    grants = 0;
    for (int k = 0; k < 8; k++) begin
      aIn[1] = 32'h5000_0000 + k;
      @(negedge clk);
      if (req_ready[1]) grants++;
      if (k == 7) check("t3_stalled", req_ready, 0);
      tick();
    end
    check("t3_grants", grants, 2);
    rspReady[1] = 1'b1;
    @(negedge clk);
    check("t3_pop_cycle_ready", req_ready, 0);
    tick();
    rspReady[1] = 1'b0;
    grants = 0;
    for (int k = 0; k < 7; k++) begin
      aIn[1] = 32'h5100_0000 + k;
      @(negedge clk);
      if (req_ready[1]) grants++;
      tick();
    end
    check("t3_regrant", grants, 1);
    reqValid = '0;
    rspReady = '1;
    repeat (8) tick();

    // Issue and pop in the same cycle at credit 1.
    rspReady = '0;
    reqValid = 4'b0001;
    aIn[0] = 32'h6000_0000;
    @(negedge clk);
    check("t4_first_issue", req_ready, 4'b0001);
    tick();
    reqValid = '0;
    repeat (5) tick();
    @(negedge clk);
    check("t4_fifo_one", rsp_valid, 4'b0001);
    tick();
    reqValid = 4'b0001;
    rspReady = 4'b0001;
    aIn[0] = 32'h6000_0001;
    @(negedge clk);
    check("t4_mixed_ready", req_ready, 4'b0001);
    tick();
    rspReady = '0;
    aIn[0] = 32'h6000_0002;
    @(negedge clk);
    check("t4_credit_kept", req_ready, 4'b0001);
    tick();
    aIn[0] = 32'h6000_0003;
    @(negedge clk);
    check("t4_credit_zero", req_ready, 0);
    tick();
    reqValid = '0;
    repeat (6) tick();
    @(negedge clk);
    check("t4_two_queued", rsp_valid, 4'b0001);
    tick();
    rspReady = '1;
    repeat (4) tick();

    // Result with no tag in flight.
    @(negedge clk);
    check("t5_tag_err_before", tag_err, 0);
    tick();
    inject  = 1'b1;
    injData = 32'hDEAD_BEEF;
    tick();
    inject = 1'b0;
    @(negedge clk);
    check("t5_tag_err_set", tag_err, 1);
    repeat (3) tick();
    @(negedge clk);
    check("t5_tag_err_sticky", tag_err, 1);
    check("t5_no_push", rsp_valid, 0);
    tick();
    reqValid = 4'b0100;
    rspReady = '0;
    grants = 0;
    for (int k = 0; k < 6; k++) begin
      aIn[2] = 32'h7000_0000 + k;
      @(negedge clk);
      if (req_ready[2]) grants++;
      tick();
    end
    check("t5_credits_intact", grants, 2);
    reqValid = '0;
    rspReady = '1;
    repeat (8) tick();

    // Asynchronous reset with three operations in flight.
    reqValid = 4'b0111;
    for (int i = 0; i < NR; i++) aIn[i] = 32'h8000_0000 + i;
    repeat (3) tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_req_ready", req_ready, 0);
    check("t6_fma_issue", fma_issue, 0);
    check("t6_fma_a", fma_a, 0);
    check("t6_fma_op", fma_op, 0);
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_rsp_data", 64'(rsp_data[63:0]) | 64'(rsp_data[127:64]), 0);
    check("t6_tag_err", tag_err, 0);
    reqValid = '0;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("t6_stale_dropped", rsp_valid, 0);
    check("t6_stale_tag_err", tag_err, 1);
    tick();
    reqValid = 4'b1000;
    rspReady = '0;
    grants = 0;
    for (int k = 0; k < 6; k++) begin
      aIn[3] = 32'h9000_0000 + k;
      @(negedge clk);
      if (req_ready[3]) grants++;
      tick();
    end
    check("t6_credits_reset", grants, 2);
    reqValid = '0;
    rspReady = '1;
    repeat (8) tick();

    total = 0;
    for (int i = 0; i < NR; i++) total += expQ[i].size();
    check("final_queue_empty", total, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
